// File: rtl/cpu_clk_ctrl.sv
// CPU clock controller: divides the board clock into a gated CPU clock with
// run / single-step / halt / burst modes, plus a rise tick and cycle counter.
module cpu_clk_ctrl #(
    parameter int unsigned DIV_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned DEB_CYCLES = 20
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic [1:0]           iMode,
    input  logic [DIV_WIDTH-1:0] iHalfPeriod,
    input  logic                 iStepBtn,
    input  logic [CNT_WIDTH-1:0] iBurstLen,
    output logic                 oCpuClk,
    output logic                 oTick,
    output logic [CNT_WIDTH-1:0] oCycleCnt,
    output logic                 oBusy
);

    localparam int unsigned    DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_STEP  = 2'b01,
        MODE_HALT  = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_e;

    mode_e                mode;
    logic [DIV_WIDTH-1:0] half_m1;

    state_e               state_q;
    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic                 cpu_clk_q;
    logic                 tick_q;
    logic [CNT_WIDTH-1:0] cycle_cnt_q;

    logic [1:0]           sync_q;
    logic                 step_sync;
    logic                 deb_q,   deb_d;
    logic [DEB_W-1:0]     stab_q,  stab_d;
    logic                 deb_rise;

    logic                 pending_q,   pending_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                 busy_q,      busy_d;
    mode_e                mode_prev_q;

    logic                 permit;
    logic                 rise;

    assign mode      = mode_e'(iMode);
    // A half period of 0 behaves as 1, so the terminal count is clamped at 0.
    assign half_m1   = (iHalfPeriod == '0) ? '0 : iHalfPeriod - DIV_WIDTH'(1);
    assign step_sync = sync_q[1];

    // Step button: two-flop synchroniser into the debouncer.
    always_ff @(posedge iClk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!iRst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], iStepBtn};
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        deb_d    = deb_q;
        stab_d   = '0;
        deb_rise = 1'b0;
        if (step_sync != deb_q) begin
            if (stab_q == DEB_LAST) begin
                deb_d    = step_sync;
                deb_rise = step_sync;
            end else begin
                stab_d = stab_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            deb_q  <= 1'b0;
            stab_q <= '0;
        end else begin
            deb_q  <= deb_d;
            stab_q <= stab_d;
        end
    end

    // Rise gating: only the LOW->HIGH transition ever waits on the mode.
    always_comb begin
        permit = 1'b0;
        case (mode)
            MODE_RUN:   permit = 1'b1;
            MODE_STEP:  permit = pending_q;
            MODE_HALT:  permit = 1'b0;
            MODE_BURST: permit = (remaining_q != '0);
            default:    permit = 1'b0;
        endcase
    end

    assign rise = (state_q == ST_LOW) && (div_cnt_q >= half_m1) && permit;

    always_comb begin
        pending_d = pending_q;
        if (mode != MODE_STEP) begin
            pending_d = 1'b0;
        end else if (deb_rise) begin
            // A fresh press wins over a rise consuming the queued one.
            pending_d = 1'b1;
        end else if (rise) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        remaining_d = remaining_q;
        if (mode != MODE_BURST) begin
            remaining_d = '0;
        end else if (mode_prev_q != MODE_BURST) begin
            remaining_d = iBurstLen;
        end else if (rise) begin
            remaining_d = remaining_q - CNT_WIDTH'(1);
        end
        busy_d = (mode == MODE_BURST) && (remaining_d != '0);
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            pending_q   <= 1'b0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            mode_prev_q <= MODE_RUN;
        end else begin
            pending_q   <= pending_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            mode_prev_q <= mode;
        end
    end

    // Clock phase FSM with registered clock, tick and cycle counter.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q     <= ST_LOW;
            div_cnt_q   <= '0;
            cpu_clk_q   <= 1'b0;
            tick_q      <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                ST_LOW: begin
                    if (rise) begin
                        state_q     <= ST_HIGH;
                        cpu_clk_q   <= 1'b1;
                        div_cnt_q   <= '0;
                        tick_q      <= 1'b1;
                        cycle_cnt_q <= cycle_cnt_q + CNT_WIDTH'(1);
                    end else if (div_cnt_q >= half_m1) begin
                        div_cnt_q <= half_m1;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
                    end
                end
                ST_HIGH: begin
                    // >= so a half period shortened mid-phase still ends the phase.
                    if (div_cnt_q >= half_m1) begin
                        state_q   <= ST_LOW;
                        cpu_clk_q <= 1'b0;
                        div_cnt_q <= '0;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state_q   <= ST_LOW;
                    cpu_clk_q <= 1'b0;
                    div_cnt_q <= '0;
                end
            endcase
        end
    end

    assign oCpuClk   = cpu_clk_q;
    assign oTick     = tick_q;
    assign oCycleCnt = cycle_cnt_q;
    assign oBusy     = busy_q;

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Parametrised CPU clock controller for the FPGA board top. It derives the processor clock from the board clock with a runtime-programmable half period. It supports four modes: free run, debounced single-step, halt, and N-cycle burst. It also provides a rise-tick pulse and a cycle counter for the debug display.

Parameters:
DIV_WIDTH, 32, width of the half-period input and divider counter
CNT_WIDTH, 16, width of the burst length and cycle counter
DEB_CYCLES, 20, consecutive stable board-clock cycles needed to accept a step-button level change

Ports:
iClk  in  1  board clock; the only clock in the block
iRst_n  in  1  reset, synchronous, active-low
iMode  in  2  00 run, 01 step, 10 halt, 11 burst
iHalfPeriod  in  DIV_WIDTH  half period H in iClk cycles; value 0 is treated as 1
iStepBtn  in  1  raw, asynchronous, bouncing step push-button (active-high)
iBurstLen  in  CNT_WIDTH  number of CPU cycles issued per burst
oCpuClk  out  1  generated CPU clock, driven from a register
oTick  out  1  one-iClk pulse on the first cycle oCpuClk is high
oCycleCnt  out  CNT_WIDTH  count of oCpuClk rising edges since reset; wraps to 0
oBusy  out  1  high while mode is 11 and burst cycles remain

Behaviour:
- Reset (iRst_n low at a posedge iClk): oCpuClk=0, oTick=0, oCycleCnt=0, oBusy=0, divider cnt=0, pending=0, remaining=0, debounced=0, sync FFs=0, mode_prev=00. Reset mid-high-phase forces oCpuClk to 0 on that edge.
- H = max(iHalfPeriod,1). H is sampled continuously; a change takes effect on the comparison at the next toggle.
- States:
  - LOW: oCpuClk=0. cnt increments, saturating at H-1.
  - LOW->HIGH: when cnt>=H-1 AND permit. On that edge: oCpuClk<=1, cnt<=0, oTick<=1, oCycleCnt<=oCycleCnt+1.
  - HIGH: oCpuClk=1. cnt increments.
  - HIGH->LOW: when cnt==H-1. On that edge: oCpuClk<=0, cnt<=0.
- oTick is 0 in every other cycle.
- permit:
  - run: always 1
  - step: pending
  - halt: 0
  - burst: remaining!=0
- A high phase always completes at full length, whatever the mode changes to. Only rises are gated.
- If the low phase completes without permit, the block holds in LOW (cnt saturated). It rises on the first edge where permit=1, i.e. 1 iClk after permit asserts.
- Run period = 2H iClk cycles, 50% duty.
- Step button path:
  - 2-FF synchroniser, then debouncer.
  - The debounced level changes only after the synchronised input differs from it for DEB_CYCLES consecutive cycles. Any reversion resets the stability counter.
  - A debounced 0->1 edge in step mode sets pending.
  - pending clears on the rise it permits, and whenever mode!=01.
  - If a new edge and a consuming rise occur in the same cycle, pending stays 1. At most one step is queued.
- Burst:
  - An edge where iMode==11 and mode_prev!=11 loads remaining<=iBurstLen.
  - Each rise in burst mode decrements remaining.
  - Remaining in mode 11 does not reload; exit and re-entry is required.
  - Leaving mode 11 clears remaining.
  - iBurstLen=0 issues no cycles.
- oBusy = (iMode==11) && (remaining!=0), registered alongside remaining.
- oCycleCnt wraps from all-ones to 0 without a flag.
- mode_prev <= iMode every cycle.

Test Plan:
1. Reset, mode 00, H=4 for 40 cycles -> oCpuClk high 4 / low 4. First rise at cycle 4 after reset release. oTick pulses every 8 cycles. oCycleCnt=5 after the 5th rise.
2. Mode 00, H=4; switch to 10 on the 2nd cycle of a high phase -> high lasts the full 4 cycles, then oCpuClk stays 0 and oCycleCnt stays frozen for 100 cycles.
3. Mode 01, DEB_CYCLES=20. Apply bounce pulses of 5 and 10 cycles, then hold high for 30 cycles -> exactly one rise. It occurs 1 cycle after pending sets (~2+20 cycles after stable high). oCycleCnt +1.
4. Mode 01, two clean presses 50 cycles apart with H=100 -> only one rise during the first high phase; the second rise follows immediately after the first low phase completes.
5. iBurstLen=3, switch 10->11 with H=2 -> exactly 3 rises. oBusy falls on the edge of the 3rd rise. Exit to 10 and re-enter 11 -> 3 more rises.
6. iHalfPeriod=0 in mode 00 -> period of 2 iClk. Drive iRst_n low for one edge while oCpuClk=1 -> oCpuClk=0, oCycleCnt=0 on the next cycle.
